mux_src_arbiter: RTL and testbench
==================================

Name: mux_src_arbiter

Overview:
- Upstream control stage for the 32-bit two-input select MUX (DI1/DI2/SelData/DO).
- Arbitrates between two producers with valid/ready handshakes and drives SelData so the MUX routes the granted producer.
- Registers the MUX output DO into a one-entry output stage with its own valid/ready handshake.
- Uses round-robin arbitration with bounded bursts and keeps per-source transfer counters.

Parameters:
- WIDTH, 32, data width; matches MUX DI1/DI2/DO.
- BURST, 4, max consecutive transfers granted to one source while the other is waiting; legal range 1..15.
- CNT_W, 16, width of per-source transfer counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Valid1  input  1  source 1 (MUX DI1 side) has a word.
- Ready1  output  1  source 1 word accepted this cycle.
- Valid2  input  1  source 2 (MUX DI2 side) has a word.
- Ready2  output  1  source 2 word accepted this cycle.
- SelData  output  1  MUX select: 0 = DI1, 1 = DI2.
- MuxDO  input  WIDTH  MUX output DO.
- DataOut  output  WIDTH  registered word.
- OutValid  output  1  DataOut valid.
- OutReady  input  1  downstream accepts DataOut.
- Count1  output  CNT_W  source 1 transfers since reset.
- Count2  output  CNT_W  source 2 transfers since reset.

Behaviour:
- Reset (async, rst_n=0): DataOut=0, OutValid=0, SelData=0, Count1=Count2=0, LastGrant=2, BurstCnt=0. Ready1=Ready2=0 while reset is asserted.
- Space = !OutValid || OutReady, combinational. No grant is issued when Space=0.
- Grant (combinational, requires Space=1):
  - Only one source valid: that source is granted.
  - Both valid: the previous-grant source keeps the grant if BurstCnt < BURST; otherwise the other source is granted.
  - Tie with no prior history after reset: source 1 wins, because LastGrant resets to 2.
- Ready1/Ready2 equal the grant; they are one-hot or both 0. A transfer occurs when Valid_i && Ready_i.
- SelData:
  - Combinational: 1 when source 2 is granted, 0 when source 1 is granted.
  - With no grant, holds the registered value of the last grant, so no toggling occurs while idle.
- Capture: on a transfer cycle, MuxDO is registered into DataOut and OutValid=1 on the next edge. Latency is 1 cycle from handshake to OutValid.
- Drain: on OutValid && OutReady with no new transfer, OutValid goes to 0 next edge. DataOut holds its last value.
- Simultaneous drain and transfer: DataOut takes the new word and OutValid stays 1. Full throughput is 1 word/cycle with OutReady held high.
- Backpressure: with OutValid=1 and OutReady=0, Ready1=Ready2=0. DataOut and OutValid are stable.
- Burst counter:
  - A transfer from the same source as LastGrant gives BurstCnt+1, saturating at BURST.
  - A transfer from the other source gives BurstCnt=1 and LastGrant updates.
  - Idle cycles do not reset BurstCnt.
- Counters: Count_i increments by 1 on each source-i transfer and wraps modulo 2^CNT_W (0xFFFF -> 0x0000 at default).
- Reset mid-operation: all state clears immediately. A word in flight is dropped and is not counted.
- Sources are not required to hold Valid when not granted. The arbiter does not depend on source stability.

Test Plan:
- Reset then Valid1=1 with MuxDO=0xA5A5A5A5, OutReady=1 -> Ready1=1, SelData=0 in the same cycle; next cycle DataOut=0xA5A5A5A5, OutValid=1, Count1=1.
- Both valid continuously with OutReady=1 and BURST=4 -> grant pattern 1,1,1,1,2,2,2,2,1... SelData follows with 0/1 on the same cycles; Count1=Count2=8 after 16 cycles.
- Transfer then OutReady=0 for 5 cycles with both valid -> Ready1=Ready2=0 throughout, DataOut/OutValid unchanged; OutReady=1 -> next transfer accepted in that same cycle.
- Only Valid2 asserted for 20 cycles -> source 2 granted every cycle regardless of BURST; Count2=20; SelData holds 1 through the following idle cycles.
- Preload Count1 near wrap by issuing 65536 source-1 transfers -> Count1 reads 0x0000. A further transfer -> 0x0001.
- Deassert rst_n mid-stream while OutValid=1 -> OutValid, DataOut, SelData and both counts go to 0 asynchronously. After release, a both-valid tie grants source 1 first.

Source files
------------

// File: rtl/mux_src_arbiter_if.sv
// Handshake and data bundle between two producers, the 32-bit select MUX and the arbiter.
// The arbiter uses the slave modport; the producer/consumer side uses master.
interface mux_src_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             Valid1;
  logic             Ready1;
  logic             Valid2;
  logic             Ready2;
  logic             SelData;
  logic [WIDTH-1:0] MuxDO;
  logic [WIDTH-1:0] DataOut;
  logic             OutValid;
  logic             OutReady;
  logic [CNT_W-1:0] Count1;
  logic [CNT_W-1:0] Count2;

  modport slave (
    input  Valid1, Valid2, MuxDO, OutReady,
    output Ready1, Ready2, SelData, DataOut, OutValid, Count1, Count2
  );

  modport master (
    output Valid1, Valid2, MuxDO, OutReady,
    input  Ready1, Ready2, SelData, DataOut, OutValid, Count1, Count2
  );
endinterface

// File: rtl/mux_src_arbiter.sv
// Round-robin, burst-bounded arbiter steering the DI1/DI2 MUX into a one-entry output register (1 cycle).
// Backpressure: no grant while the output register is full and OutReady is low.
module mux_src_arbiter #(
  parameter int WIDTH = 32,
  parameter int BURST = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mux_src_arbiter_if.slave      bus
);

  typedef enum logic {
    SRC1 = 1'b0,
    SRC2 = 1'b1
  } src_e;

  localparam logic [3:0] BURST_L = 4'(BURST);

  src_e             last_q;
  logic [3:0]       burst_q;
  logic             sel_q;
  logic [WIDTH-1:0] data_q;
  logic             vld_q;
  logic [CNT_W-1:0] cnt1_q;
  logic [CNT_W-1:0] cnt2_q;

  logic space;
  logic keep;
  logic g1;
  logic g2;
  logic sel;
  src_e xfer_src;

  always_comb begin
    space    = !vld_q || bus.OutReady;
    // burst_q is 0 only before the first transfer after reset, so a fresh tie
    // is handed to the source other than LastGrant (source 1).
    keep     = (burst_q != 4'd0) && (burst_q < BURST_L);
    g1       = 1'b0;
    g2       = 1'b0;
    if (rst_n && space) begin
      if (bus.Valid1 && bus.Valid2) begin
        if ((last_q == SRC1) == keep) g1 = 1'b1;
        else                          g2 = 1'b1;
      end else if (bus.Valid1) begin
        g1 = 1'b1;
      end else if (bus.Valid2) begin
        g2 = 1'b1;
      end
    end
    sel      = g2 ? 1'b1 : (g1 ? 1'b0 : sel_q);
    xfer_src = g2 ? SRC2 : SRC1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= SRC2;
      burst_q <= 4'd0;
      sel_q   <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      cnt1_q  <= '0;
      cnt2_q  <= '0;
    end else begin
      sel_q <= sel;
      if (g1 || g2) begin
        data_q <= bus.MuxDO;
        vld_q  <= 1'b1;
        if (xfer_src == last_q) begin
          burst_q <= (burst_q < BURST_L) ? burst_q + 4'd1 : BURST_L;
        end else begin
          burst_q <= 4'd1;
          last_q  <= xfer_src;
        end
      end else if (bus.OutReady) begin
        vld_q <= 1'b0;
      end
      if (g1) cnt1_q <= cnt1_q + 1'b1;
      if (g2) cnt2_q <= cnt2_q + 1'b1;
    end
  end

  assign bus.Ready1   = g1;
  assign bus.Ready2   = g2;
  assign bus.SelData  = sel;
  assign bus.DataOut  = data_q;
  assign bus.OutValid = vld_q;
  assign bus.Count1   = cnt1_q;
  assign bus.Count2   = cnt2_q;

endmodule

// File: tb/tb_mux_src_arbiter.sv
// Directed bench for mux_src_arbiter: inputs change on the falling edge, outputs sampled away from edges.
module tb_mux_src_arbiter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mux_src_arbiter_if #(.WIDTH(32), .CNT_W(16)) bus ();

  mux_src_arbiter #(.WIDTH(32), .BURST(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    bus.Valid1   = 1'b0;
    bus.Valid2   = 1'b0;
    bus.MuxDO    = 32'h0;
    bus.OutReady = 1'b1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.Valid1   = 1'b1;
    bus.Valid2   = 1'b1;
    bus.MuxDO    = 32'hFFFF_FFFF;
    bus.OutReady = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (bus.Ready1 !== 1'b0 || bus.Ready2 !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b want 00", bus.Ready1, bus.Ready2);
    end
    checks++;
    if (bus.OutValid !== 1'b0 || bus.DataOut !== 32'h0) begin
      errors++; $display("FAIL reset_out: got vld=%b dat=%h want 0/0", bus.OutValid, bus.DataOut);
    end
    checks++;
    if (bus.SelData !== 1'b0 || bus.Count1 !== 16'h0 || bus.Count2 !== 16'h0) begin
      errors++; $display("FAIL reset_sel_cnt: got sel=%b c1=%h c2=%h want 0", bus.SelData, bus.Count1, bus.Count2);
    end
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.Valid1 = 1'b1;
    bus.MuxDO  = 32'hA5A5_A5A5;
    #1;
    checks++;
    if (bus.Ready1 !== 1'b1 || bus.Ready2 !== 1'b0 || bus.SelData !== 1'b0) begin
      errors++; $display("FAIL single_grant: got r1=%b r2=%b sel=%b want 1 0 0", bus.Ready1, bus.Ready2, bus.SelData);
    end
    @(posedge clk);
    #1;
    bus.Valid1 = 1'b0;
    checks++;
    if (bus.DataOut !== 32'hA5A5_A5A5 || bus.OutValid !== 1'b1 || bus.Count1 !== 16'd1) begin
      errors++; $display("FAIL single_capture: got dat=%h vld=%b c1=%0d want a5a5a5a5 1 1", bus.DataOut, bus.OutValid, bus.Count1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.OutValid !== 1'b0 || bus.DataOut !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL single_drain: got vld=%b dat=%h want 0 a5a5a5a5", bus.OutValid, bus.DataOut);
    end
  endtask

  task automatic test_round_robin();
    logic exp2;
    apply_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      bus.Valid1   = 1'b1;
      bus.Valid2   = 1'b1;
      bus.OutReady = 1'b1;
      bus.MuxDO    = 32'h1000_0000 + c;
      exp2         = ((c / 4) % 2) == 1;
      #1;
      checks++;
      if (bus.Ready1 !== !exp2 || bus.Ready2 !== exp2 || bus.SelData !== exp2) begin
        errors++; $display("FAIL rr_grant c=%0d: got r1=%b r2=%b sel=%b want src2=%b", c, bus.Ready1, bus.Ready2, bus.SelData, exp2);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.DataOut !== 32'h1000_0000 + c || bus.OutValid !== 1'b1) begin
        errors++; $display("FAIL rr_data c=%0d: got %h vld=%b want %h 1", c, bus.DataOut, bus.OutValid, 32'h1000_0000 + c);
      end
    end
    bus.Valid1 = 1'b0;
    bus.Valid2 = 1'b0;
    checks++;
    if (bus.Count1 !== 16'd8 || bus.Count2 !== 16'd8) begin
      errors++; $display("FAIL rr_counts: got c1=%0d c2=%0d want 8 8", bus.Count1, bus.Count2);
    end
  endtask

  task automatic test_backpressure();
    // last grant was a full burst of source 2, so source 1 wins next
    @(negedge clk);
    bus.Valid1   = 1'b1;
    bus.Valid2   = 1'b1;
    bus.OutReady = 1'b1;
    bus.MuxDO    = 32'h1111_2222;
    #1;
    checks++;
    if (bus.Ready1 !== 1'b1 || bus.Ready2 !== 1'b0) begin
      errors++; $display("FAIL bp_first: got r1=%b r2=%b want 1 0", bus.Ready1, bus.Ready2);
    end
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.OutReady = 1'b0;
      bus.MuxDO    = 32'hBAD0_0000 + i;
      #1;
      checks++;
      if (bus.Ready1 !== 1'b0 || bus.Ready2 !== 1'b0) begin
        errors++; $display("FAIL bp_ready i=%0d: got r1=%b r2=%b want 0 0", i, bus.Ready1, bus.Ready2);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.DataOut !== 32'h1111_2222 || bus.OutValid !== 1'b1) begin
        errors++; $display("FAIL bp_hold i=%0d: got %h vld=%b want 11112222 1", i, bus.DataOut, bus.OutValid);
      end
    end
    @(negedge clk);
    bus.OutReady = 1'b1;
    bus.MuxDO    = 32'h3333_4444;
    #1;
    checks++;
    if (bus.Ready1 !== 1'b1 || bus.Ready2 !== 1'b0) begin
      errors++; $display("FAIL bp_release: got r1=%b r2=%b want 1 0", bus.Ready1, bus.Ready2);
    end
    @(posedge clk);
    #1;
    bus.Valid1 = 1'b0;
    bus.Valid2 = 1'b0;
    checks++;
    if (bus.DataOut !== 32'h3333_4444 || bus.Count1 !== 16'd10 || bus.Count2 !== 16'd8) begin
      errors++; $display("FAIL bp_after: got %h c1=%0d c2=%0d want 33334444 10 8", bus.DataOut, bus.Count1, bus.Count2);
    end
  endtask

  task automatic test_only_src2();
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.Valid2 = 1'b1;
      bus.MuxDO  = 32'h2000_0000 + c;
      #1;
      checks++;
      if (bus.Ready2 !== 1'b1 || bus.Ready1 !== 1'b0 || bus.SelData !== 1'b1) begin
        errors++; $display("FAIL src2_grant c=%0d: got r1=%b r2=%b sel=%b want 0 1 1", c, bus.Ready1, bus.Ready2, bus.SelData);
      end
      @(posedge clk);
    end
    #1;
    bus.Valid2 = 1'b0;
    checks++;
    if (bus.Count2 !== 16'd20 || bus.Count1 !== 16'd0 || bus.DataOut !== 32'h2000_0013) begin
      errors++; $display("FAIL src2_count: got c2=%0d c1=%0d dat=%h want 20 0 20000013", bus.Count2, bus.Count1, bus.DataOut);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.SelData !== 1'b1 || bus.Ready2 !== 1'b0) begin
        errors++; $display("FAIL src2_idle i=%0d: got sel=%b r2=%b want 1 0", i, bus.SelData, bus.Ready2);
      end
    end
    checks++;
    if (bus.OutValid !== 1'b0) begin
      errors++; $display("FAIL src2_drain: got vld=%b want 0", bus.OutValid);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    @(negedge clk);
    bus.Valid1 = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    bus.Valid1 = 1'b0;
    checks++;
    if (bus.Count1 !== 16'h0000 || bus.Count2 !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero: got c1=%h c2=%h want 0000 0000", bus.Count1, bus.Count2);
    end
    @(negedge clk);
    bus.Valid1 = 1'b1;
    @(posedge clk);
    #1;
    bus.Valid1 = 1'b0;
    checks++;
    if (bus.Count1 !== 16'h0001) begin
      errors++; $display("FAIL wrap_one: got c1=%h want 0001", bus.Count1);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    bus.Valid2   = 1'b1;
    bus.MuxDO    = 32'hDEAD_BEEF;
    bus.OutReady = 1'b0;
    @(posedge clk);
    #1;
    bus.Valid2 = 1'b0;
    checks++;
    if (bus.OutValid !== 1'b1 || bus.SelData !== 1'b1 || bus.Count2 !== 16'd1) begin
      errors++; $display("FAIL mid_setup: got vld=%b sel=%b c2=%0d want 1 1 1", bus.OutValid, bus.SelData, bus.Count2);
    end
    @(negedge clk);
    bus.Valid1 = 1'b1;
    bus.Valid2 = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.OutValid !== 1'b0 || bus.DataOut !== 32'h0 || bus.SelData !== 1'b0) begin
      errors++; $display("FAIL mid_async_out: got vld=%b dat=%h sel=%b want 0 0 0", bus.OutValid, bus.DataOut, bus.SelData);
    end
    checks++;
    if (bus.Count1 !== 16'd0 || bus.Count2 !== 16'd0 || bus.Ready1 !== 1'b0 || bus.Ready2 !== 1'b0) begin
      errors++; $display("FAIL mid_async_cnt: got c1=%0d c2=%0d r1=%b r2=%b want 0", bus.Count1, bus.Count2, bus.Ready1, bus.Ready2);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.OutReady = 1'b1;
    bus.MuxDO    = 32'h0BAD_F00D;
    #1;
    checks++;
    if (bus.Ready1 !== 1'b1 || bus.Ready2 !== 1'b0 || bus.SelData !== 1'b0) begin
      errors++; $display("FAIL mid_tie: got r1=%b r2=%b sel=%b want 1 0 0", bus.Ready1, bus.Ready2, bus.SelData);
    end
    @(posedge clk);
    #1;
    bus.Valid1 = 1'b0;
    bus.Valid2 = 1'b0;
    checks++;
    if (bus.Count1 !== 16'd1 || bus.Count2 !== 16'd0 || bus.DataOut !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL mid_after: got c1=%0d c2=%0d dat=%h want 1 0 0badf00d", bus.Count1, bus.Count2, bus.DataOut);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_only_src2();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
